rv32_avalon_lsu: RTL and testbench
==================================

RV32_AVALON_LSU -- requirements
Module: rv32_avalon_lsu

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning core and Avalon address width.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 255, meaning maximum cycles a single bus phase may wait before abort.
REQ-003 The block SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have core-side ports: req_valid in 1 (access request); req_we in 1 (1 = store); req_funct3 in 3 (RV32 load/store width code); req_addr in ADDR_W (byte address); req_wdata in 32 (store data).
REQ-006 The block SHALL have core response ports: stall out 1 (core holds PC and request); rsp_valid out 1 (one-cycle completion pulse); rsp_rdata out 32 (extended load data); rsp_err out 1 (misaligned or timeout).
REQ-007 The block SHALL have Avalon-MM master ports: avm_address out ADDR_W; avm_read out 1; avm_write out 1; avm_writedata out 32; avm_byteenable out 4; avm_waitrequest in 1; avm_readdata in 32; avm_readdatavalid in 1.

Function
REQ-008 The FSM SHALL have states IDLE, CMD, WAIT_RD and DONE.
REQ-009 In IDLE with req_valid=1 and an aligned access, the block SHALL register address, byteenable, writedata and direction, and go to CMD.
REQ-010 In IDLE with req_valid=1 and a misaligned access, the block SHALL issue no bus cycle, set a pending error and go to DONE.
- Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
REQ-011 In CMD, avm_read or avm_write SHALL be asserted from registers, and address, byteenable and writedata SHALL stay stable while avm_waitrequest=1.
REQ-012 The command SHALL be accepted in the first CMD cycle with avm_waitrequest=0.
- Write accepted: go to DONE.
- Read accepted: go to WAIT_RD.
REQ-013 In WAIT_RD, on avm_readdatavalid=1 the block SHALL capture avm_readdata and go to DONE.
- avm_readdatavalid in any other state SHALL be ignored.
REQ-014 avm_address SHALL be {req_addr[ADDR_W-1:2], 2'b00}.
REQ-015 avm_byteenable SHALL be set by access width, for loads and stores alike:
- Byte: 4'b0001 << addr[1:0].
- Half: 4'b0011 << {addr[1],1'b0}.
- Word: 4'b1111.
REQ-016 avm_writedata SHALL be {4{wdata[7:0]}} for SB, {2{wdata[15:0]}} for SH, and wdata for SW.
REQ-017 Load data SHALL be taken from the addressed lane and extended:
- LB/LH: sign-extended.
- LBU/LHU: zero-extended.
- LW: unchanged.
REQ-018 stall SHALL be 1 when req_valid=1 and state is not DONE, and 0 otherwise.
- An aligned or misaligned request therefore stalls at least one cycle.
REQ-019 In DONE, rsp_valid SHALL be 1 for exactly one cycle, with rsp_err and rsp_rdata valid in that cycle; the state then returns to IDLE.
- rsp_rdata SHALL be 0 for stores and errors.
REQ-020 A phase counter SHALL clear on entry to CMD and WAIT_RD, and increment each cycle spent in those states.
REQ-021 When the phase counter reaches TIMEOUT_CYC, the block SHALL deassert avm_read/avm_write, set rsp_err and go to DONE.
REQ-022 A request with req_valid=1 in the cycle after DONE SHALL be treated as a new access; there SHALL be no back-to-back bypass.

Reset
REQ-023 On reset_n=0, the block SHALL immediately (asynchronously) force state IDLE and counter 0, with these outputs: avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, avm_byteenable=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
REQ-024 Reset during CMD or WAIT_RD SHALL abandon the transfer with no response pulse; a late avm_readdatavalid after reset release SHALL be ignored.

Structure
REQ-025 Package rv32_lsu_pkg SHALL hold the FSM state enum and the funct3 constants (LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2).
REQ-026 The byteenable, write-replication and load-extension logic SHALL be one combinational sub-module, rv32_lsu_align; the FSM and counter stay in rv32_avalon_lsu.

Verification
REQ-027 SW with addr=0x104, wdata=0xDEADBEEF and waitrequest=0 -> one write cycle with avm_address=0x104 and byteenable=1111, rsp_valid 1 cycle later, stall for 2 cycles total.
REQ-028 SB with addr=0x203, wdata=0x000000A5 and waitrequest held 3 cycles -> writedata=0xA5A5A5A5, byteenable=1000 stable for 4 cycles, single write accept.
REQ-029 LB with addr=0x102, readdata=0x00800000 and readdatavalid 2 cycles after accept -> rsp_rdata=0xFFFFFF80; same access with LBU -> rsp_rdata=0x00000080.
REQ-030 LW with addr=0x106 -> no avm_read, rsp_valid with rsp_err=1 and rsp_rdata=0.
REQ-031 LW with readdatavalid never asserted and TIMEOUT_CYC=8 -> avm_read accepted, rsp_err=1 pulse after 8 WAIT_RD cycles, then IDLE.
REQ-032 reset_n low while in CMD with waitrequest=1 -> avm_read drops the same cycle, no rsp_valid; the next LW completes normally.

Source files
------------

// File: rtl/rv32_lsu_pkg.sv
// Shared definitions for the RV32 load/store unit: FSM encodings, funct3 width
// codes and the alignment rule for a request.
package rv32_lsu_pkg;

    typedef logic [1:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE    = 2'd0;
    localparam lsu_state_t ST_CMD     = 2'd1;
    localparam lsu_state_t ST_WAIT_RD = 2'd2;
    localparam lsu_state_t ST_DONE    = 2'd3;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    // funct3[1:0] alone selects the access width for loads and stores alike.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
        case (width)
            2'b00:   return 1'b0;
            2'b01:   return addr_lo[0];
            default: return |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/rv32_lsu_align.sv
// Combinational lane steering: byteenable generation, store data replication
// and load lane extraction with sign/zero extension.
module rv32_lsu_align
    import rv32_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byteenable,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;
    logic [7:0]  lane8;
    logic [15:0] lane16;
    logic        sign_en;

    // Shifting the whole word by the byte offset brings the addressed lane to bit 0.
    always_comb begin
        shifted    = rdata >> {addr_lo, 3'b000};
        lane8      = shifted[7:0];
        lane16     = shifted[15:0];
        sign_en    = ~funct3[2];
        byteenable = 4'b1111;
        wdata_rep  = wdata;
        rdata_ext  = rdata;
        case (funct3[1:0])
            2'b00: begin
                byteenable = 4'b0001 << addr_lo;
                wdata_rep  = {4{wdata[7:0]}};
                rdata_ext  = {{24{sign_en & lane8[7]}}, lane8};
            end
            2'b01: begin
                byteenable = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep  = {2{wdata[15:0]}};
                rdata_ext  = {{16{sign_en & lane16[15]}}, lane16};
            end
            default: begin
                byteenable = 4'b1111;
                wdata_rep  = wdata;
                rdata_ext  = rdata;
            end
        endcase
    end

endmodule

// File: rtl/rv32_avalon_lsu.sv
// RV32 load/store unit bridging a stalling core interface onto an Avalon-MM
// master with waitrequest and pipelined readdatavalid, plus a per-phase timeout.
module rv32_avalon_lsu
    import rv32_lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
);

    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       funct3_q;
    logic [1:0]       addr_lo_q;
    logic             err_q;
    logic [31:0]      rdata_q;

    logic [2:0]  align_f3;
    logic [1:0]  align_lo;
    logic [3:0]  align_be;
    logic [31:0] align_wd;
    logic [31:0] align_rd;
    logic        misaligned;
    logic        timeout;
    logic        in_done;

    // In IDLE the aligner looks at the live request; afterwards at the captured one.
    assign align_f3   = (state == ST_IDLE) ? req_funct3     : funct3_q;
    assign align_lo   = (state == ST_IDLE) ? req_addr[1:0]  : addr_lo_q;
    assign misaligned = is_misaligned(req_funct3[1:0], req_addr[1:0]);
    assign timeout    = (cnt == CNT_LAST);
    assign in_done    = (state == ST_DONE);

    rv32_lsu_align u_align (
        .funct3     (align_f3),
        .addr_lo    (align_lo),
        .wdata      (req_wdata),
        .rdata      (avm_readdata),
        .byteenable (align_be),
        .wdata_rep  (align_wd),
        .rdata_ext  (align_rd)
    );

    assign stall     = req_valid & ~in_done;
    assign rsp_valid = in_done;
    assign rsp_err   = in_done & err_q;
    assign rsp_rdata = in_done ? rdata_q : 32'd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            funct3_q       <= '0;
            addr_lo_q      <= '0;
            err_q          <= 1'b0;
            rdata_q        <= '0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        funct3_q  <= req_funct3;
                        addr_lo_q <= req_addr[1:0];
                        rdata_q   <= '0;
                        cnt       <= '0;
                        if (misaligned) begin
                            err_q <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            err_q          <= 1'b0;
                            avm_address    <= {req_addr[ADDR_W-1:2], 2'b00};
                            avm_byteenable <= align_be;
                            avm_writedata  <= align_wd;
                            avm_read       <= ~req_we;
                            avm_write      <= req_we;
                            state          <= ST_CMD;
                        end
                    end
                end
                ST_CMD: begin
                    if (!avm_waitrequest) begin
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        cnt       <= '0;
                        state     <= avm_write ? ST_DONE : ST_WAIT_RD;
                    end else if (timeout) begin
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        err_q     <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_RD: begin
                    if (avm_readdatavalid) begin
                        rdata_q <= align_rd;
                        state   <= ST_DONE;
                    end else if (timeout) begin
                        err_q <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_avalon_lsu.sv
// Self-checking bench for rv32_avalon_lsu: a cycle-driven Avalon slave inside
// run_access, with expected core responses held in a scoreboard queue.
module tb_rv32_avalon_lsu;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    int   checks   = 0;
    int   failures = 0;
    rsp_t exp_q[$];

    rv32_avalon_lsu #(.ADDR_W(32), .TIMEOUT_CYC(8)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_valid         (req_valid),
        .req_we            (req_we),
        .req_funct3        (req_funct3),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .stall             (stall),
        .rsp_valid         (rsp_valid),
        .rsp_rdata         (rsp_rdata),
        .rsp_err           (rsp_err),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    always #5 clk = ~clk;

    // Drives one request, plays the slave, and pops the scoreboard on rsp_valid.
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input int wait_n, input int rdv_delay,
                              input logic [31:0] rdata,
                              output int accepts, output int stall_n, output int cmd_n,
                              output int wrd_n, output logic [31:0] c_addr,
                              output logic [31:0] c_wd, output logic [3:0] c_be,
                              output bit stable);
        int   d;
        bit   got_rsp;
        rsp_t e;
        accepts = 0; stall_n = 0; cmd_n = 0; wrd_n = 0;
        c_addr = '0; c_wd = '0; c_be = '0; stable = 1'b1;
        d = -1; got_rsp = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        avm_waitrequest = 1'b0;
        #1;
        if (stall) stall_n++;
        for (int cyc = 0; cyc < 60 && !got_rsp; cyc++) begin
            @(negedge clk);
            avm_readdatavalid = 1'b0;
            avm_readdata = 32'h0;
            if (stall) stall_n++;
            if (rsp_valid) begin
                got_rsp = 1'b1;
                req_valid = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_rsp: got err=%0b rdata=%08h, required no response",
                             rsp_err, rsp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_err, rsp_rdata} !== {e.err, e.rdata}) begin
                        failures++;
                        $display("[TB] FAIL rsp: got err=%0b rdata=%08h, required err=%0b rdata=%08h",
                                 rsp_err, rsp_rdata, e.err, e.rdata);
                    end
                end
            end else if (avm_read || avm_write) begin
                cmd_n++;
                if (cmd_n == 1) begin
                    c_addr = avm_address; c_wd = avm_writedata; c_be = avm_byteenable;
                end else if (avm_address !== c_addr || avm_byteenable !== c_be ||
                             (avm_write && avm_writedata !== c_wd)) begin
                    stable = 1'b0;
                end
                if (cmd_n <= wait_n) begin
                    avm_waitrequest = 1'b1;
                end else begin
                    avm_waitrequest = 1'b0;
                    accepts++;
                    if (avm_read) d = 0;
                end
            end else begin
                avm_waitrequest = 1'b0;
                if (d >= 0) begin
                    d++;
                    wrd_n++;
                    if (d == rdv_delay) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata = rdata;
                    end
                end
            end
        end
        if (!got_rsp) begin
            checks++;
            failures++;
            $display("[TB] FAIL rsp_timeout: no rsp_valid within 60 cycles, required one pulse");
            req_valid = 1'b0;
            exp_q.delete();
            reset_n = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
        avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({avm_read, avm_write, avm_address, avm_writedata, avm_byteenable} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_bus: got rd=%0b wr=%0b addr=%08h wd=%08h be=%04b, required all 0",
                     avm_read, avm_write, avm_address, avm_writedata, avm_byteenable);
        end
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata, stall} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_rsp: got valid=%0b err=%0b rdata=%08h stall=%0b, required all 0",
                     rsp_valid, rsp_err, rsp_rdata, stall);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_store_word;
        int a, s, c, w; logic [31:0] ca, cw; logic [3:0] cb; bit st;
        exp_q.push_back('{err: 1'b0, rdata: 32'h0});
        run_access(1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 0, -1, 32'h0, a, s, c, w, ca, cw, cb, st);
        checks++;
        if (a !== 1 || c !== 1) begin
            failures++;
            $display("[TB] FAIL sw_accept: got accepts=%0d cmd=%0d, required 1/1", a, c);
        end
        checks++;
        if (ca !== 32'h104 || cb !== 4'b1111 || cw !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL sw_bus: got addr=%08h be=%04b wd=%08h, required 00000104/1111/deadbeef",
                     ca, cb, cw);
        end
        checks++;
        if (s !== 2) begin
            failures++;
            $display("[TB] FAIL sw_stall: got %0d stall cycles, required 2", s);
        end
    endtask

    task automatic test_store_byte_wait;
        int a, s, c, w; logic [31:0] ca, cw; logic [3:0] cb; bit st;
        exp_q.push_back('{err: 1'b0, rdata: 32'h0});
        run_access(1'b1, 3'd0, 32'h203, 32'h000000A5, 3, -1, 32'h0, a, s, c, w, ca, cw, cb, st);
        checks++;
        if (ca !== 32'h200 || cb !== 4'b1000 || cw !== 32'hA5A5A5A5) begin
            failures++;
            $display("[TB] FAIL sb_bus: got addr=%08h be=%04b wd=%08h, required 00000200/1000/a5a5a5a5",
                     ca, cb, cw);
        end
        checks++;
        if (c !== 4 || a !== 1 || st !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sb_hold: got cmd=%0d accepts=%0d stable=%0b, required 4/1/1", c, a, st);
        end
        checks++;
        if (s !== 5) begin
            failures++;
            $display("[TB] FAIL sb_stall: got %0d, required 5", s);
        end
        exp_q.push_back('{err: 1'b0, rdata: 32'h0});
        run_access(1'b1, 3'd1, 32'h10A, 32'h1234BEEF, 1, -1, 32'h0, a, s, c, w, ca, cw, cb, st);
        checks++;
        if (ca !== 32'h108 || cb !== 4'b1100 || cw !== 32'hBEEFBEEF || a !== 1) begin
            failures++;
            $display("[TB] FAIL sh_bus: got addr=%08h be=%04b wd=%08h acc=%0d, required 00000108/1100/beefbeef/1",
                     ca, cb, cw, a);
        end
    endtask

    task automatic test_load_extend;
        int a, s, c, w; logic [31:0] ca, cw; logic [3:0] cb; bit st;
        logic [2:0]  f3_tab [8]  = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd1, 3'd2, 3'd0, 3'd0};
        logic [31:0] ad_tab [8]  = '{32'h102, 32'h102, 32'h106, 32'h106, 32'h104, 32'h108, 32'h110, 32'h111};
        logic [31:0] rd_tab [8]  = '{32'h00800000, 32'h00800000, 32'h80017FFF, 32'h80017FFF,
                                     32'h80017FFF, 32'h12345678, 32'h807F01FE, 32'h807F01FE};
        logic [31:0] ex_tab [8]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001,
                                     32'h00007FFF, 32'h12345678, 32'hFFFFFFFE, 32'h00000001};
        logic [3:0]  be_tab [8]  = '{4'b0100, 4'b0100, 4'b1100, 4'b1100, 4'b0011, 4'b1111, 4'b0001, 4'b0010};
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{err: 1'b0, rdata: ex_tab[i]});
            run_access(1'b0, f3_tab[i], ad_tab[i], 32'h0, i % 2, 2, rd_tab[i], a, s, c, w, ca, cw, cb, st);
            checks++;
            if (cb !== be_tab[i] || ca !== {ad_tab[i][31:2], 2'b00} || a !== 1 || w !== 2) begin
                failures++;
                $display("[TB] FAIL load_bus[%0d]: got be=%04b addr=%08h acc=%0d wrd=%0d, required be=%04b acc=1 wrd=2",
                         i, cb, ca, a, w, be_tab[i]);
            end
        end
        checks++;
        if (s !== 2 + 1 + 2) begin
            failures++;
            $display("[TB] FAIL load_stall: got %0d, required 5", s);
        end
    endtask

    task automatic test_misaligned;
        int a, s, c, w; logic [31:0] ca, cw; logic [3:0] cb; bit st;
        logic        we_tab [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  f3_tab [3] = '{3'd2, 3'd1, 3'd5};
        logic [31:0] ad_tab [3] = '{32'h106, 32'h201, 32'h103};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{err: 1'b1, rdata: 32'h0});
            run_access(we_tab[i], f3_tab[i], ad_tab[i], 32'hFFFFFFFF, 0, 1, 32'hFFFFFFFF,
                       a, s, c, w, ca, cw, cb, st);
            checks++;
            if (c !== 0 || a !== 0 || s !== 1) begin
                failures++;
                $display("[TB] FAIL misaligned[%0d]: got cmd=%0d acc=%0d stall=%0d, required 0/0/1",
                         i, c, a, s);
            end
        end
    endtask

    task automatic test_timeout;
        int a, s, c, w; logic [31:0] ca, cw; logic [3:0] cb; bit st;
        exp_q.push_back('{err: 1'b1, rdata: 32'h0});
        run_access(1'b0, 3'd2, 32'h300, 32'h0, 0, -1, 32'h0, a, s, c, w, ca, cw, cb, st);
        checks++;
        if (a !== 1 || w !== 8 || s !== 10) begin
            failures++;
            $display("[TB] FAIL rd_timeout: got acc=%0d wait_rd=%0d stall=%0d, required 1/8/10", a, w, s);
        end
        exp_q.push_back('{err: 1'b1, rdata: 32'h0});
        run_access(1'b1, 3'd2, 32'h304, 32'h55AA55AA, 100, -1, 32'h0, a, s, c, w, ca, cw, cb, st);
        checks++;
        if (a !== 0 || c !== 8 || avm_write !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cmd_timeout: got acc=%0d cmd=%0d wr=%0b, required 0/8/0", a, c, avm_write);
        end
    endtask

    task automatic test_reset_mid_cmd;
        int a, s, c, w; logic [31:0] ca, cw; logic [3:0] cb; bit st;
        bit spurious;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h400;
        avm_waitrequest = 1'b1;
        @(negedge clk);
        checks++;
        if (avm_read !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_cmd_read: got avm_read=%0b, required 1", avm_read);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (avm_read !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_drop: got rd=%0b valid=%0b, required 0/0", avm_read, rsp_valid);
        end
        req_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b1; avm_readdata = 32'hCAFEF00D;
        spurious = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            avm_readdatavalid = 1'b0;
            if (rsp_valid || avm_read) spurious = 1'b1;
        end
        checks++;
        if (spurious !== 1'b0) begin
            failures++;
            $display("[TB] FAIL late_rdv: got spurious=%0b, required 0", spurious);
        end
        exp_q.push_back('{err: 1'b0, rdata: 32'h13579BDF});
        run_access(1'b0, 3'd2, 32'h400, 32'h0, 1, 1, 32'h13579BDF, a, s, c, w, ca, cw, cb, st);
        checks++;
        if (a !== 1 || s !== 4) begin
            failures++;
            $display("[TB] FAIL after_reset_lw: got acc=%0d stall=%0d, required 1/4", a, s);
        end
    endtask

    task automatic test_back_to_back;
        int a, s, c, w; logic [31:0] ca, cw; logic [3:0] cb; bit st;
        exp_q.push_back('{err: 1'b0, rdata: 32'h0});
        exp_q.push_back('{err: 1'b0, rdata: 32'hFFFFFFA5});
        run_access(1'b1, 3'd0, 32'h500, 32'h000000A5, 0, -1, 32'h0, a, s, c, w, ca, cw, cb, st);
        run_access(1'b0, 3'd0, 32'h501, 32'h0, 0, 1, 32'h0000A500, a, s, c, w, ca, cw, cb, st);
        checks++;
        if (a !== 1 || cb !== 4'b0010 || exp_q.size() !== 0) begin
            failures++;
            $display("[TB] FAIL back_to_back: got acc=%0d be=%04b pending=%0d, required 1/0010/0",
                     a, cb, exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rsp_pulse_width: got rsp_valid=%0b after DONE, required 0", rsp_valid);
        end
    endtask

    initial begin
        $display("[TB] starting rv32_avalon_lsu bench");
        test_reset();
        test_store_word();
        test_store_byte_wait();
        test_load_extend();
        test_misaligned();
        test_timeout();
        test_reset_mid_cmd();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
